// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Two-port round-robin arbiter and access sequencer for the shared data RAM.
//   Port 0 is the core load/store port, port 1 the debug/loader port. Byte
//   addresses are translated to RAM word indices; out-of-range or misaligned
//   accesses are flagged with err, never write the RAM and read back zero,
//   while keeping the same cycle timing as a good access.
//
//   Schedule: IDLE -> ACCESS -> IDLE                  (write, 2 cycles)
//             IDLE -> ACCESS -> WAIT x READ_LAT -> RESP -> IDLE (read)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   mX_req/we/addr/wdata  request from port X (X = 0,1), held until mX_gnt
//   mX_gnt                1-cycle pulse, access issued to RAM
//   mX_rvalid             1-cycle pulse, mX_rdata valid (reads only)
//   mX_rdata              read data, held until the next read response to X
//   mX_err                1-cycle pulse with completion, bad address
//   ram_we/addr/wdata     RAM command (all zero while idle)
//   ram_rdata             RAM read data, valid READ_LAT cycles after ram_addr
//   busy                  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
    parameter int unsigned RAM_WORDS = 64,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         m0_req,
    input  logic                         m0_we,
    input  logic [31:0]                  m0_addr,
    input  logic [31:0]                  m0_wdata,
    output logic                         m0_gnt,
    output logic                         m0_rvalid,
    output logic [31:0]                  m0_rdata,
    output logic                         m0_err,
    input  logic                         m1_req,
    input  logic                         m1_we,
    input  logic [31:0]                  m1_addr,
    input  logic [31:0]                  m1_wdata,
    output logic                         m1_gnt,
    output logic                         m1_rvalid,
    output logic [31:0]                  m1_rdata,
    output logic                         m1_err,
    output logic                         ram_we,
    output logic [$clog2(RAM_WORDS)-1:0] ram_addr,
    output logic [31:0]                  ram_wdata,
    input  logic [31:0]                  ram_rdata,
    output logic                         busy
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state_q;
    logic            rr_ptr_q;
    logic            port_q;
    logic            we_q;
    logic            bad_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      gnt_q;
    logic [1:0]      rvalid_q;
    logic [1:0]      err_q;
    logic [31:0]     rdata0_q;
    logic [31:0]     rdata1_q;
    logic            ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [31:0]     ram_wdata_q;

    // Winner selection and address decode of the winning request.
    logic            win_d;
    logic            we_d;
    logic [31:0]     addr_d;
    logic [31:0]     wdata_d;
    logic [31:0]     off_d;
    logic [31:0]     idx_full_d;
    logic [AW-1:0]   idx_d;
    logic            bad_d;

    always_comb begin
        // Only one requester: it wins. Both: the round-robin pointer decides.
        win_d      = (m0_req && m1_req) ? rr_ptr_q : m1_req;
        we_d       = win_d ? m1_we    : m0_we;
        addr_d     = win_d ? m1_addr  : m0_addr;
        wdata_d    = win_d ? m1_wdata : m0_wdata;
        // Full 32-bit word offset is kept so the range check sees every bit;
        // only the low AW bits drive the RAM.
        off_d      = addr_d - RAM_BASE;
        idx_full_d = off_d >> 2;
        idx_d      = idx_full_d[AW-1:0];
        bad_d      = (addr_d < RAM_BASE) || (idx_full_d >= RAM_WORDS) ||
                     (addr_d[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            bad_q       <= 1'b0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            // Handshake outputs are single-cycle pulses unless set below.
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        state_q        <= S_ACCESS;
                        port_q         <= win_d;
                        we_q           <= we_d;
                        bad_q          <= bad_d;
                        gnt_q[win_d]   <= 1'b1;
                        // A bad write completes with its grant.
                        err_q[win_d]   <= we_d & bad_d;
                        ram_we_q       <= we_d & ~bad_d;
                        ram_addr_q     <= idx_d;
                        ram_wdata_q    <= wdata_d;
                    end
                end
                S_ACCESS: begin
                    ram_we_q    <= 1'b0;
                    ram_wdata_q <= '0;
                    rr_ptr_q    <= ~port_q;
                    if (we_q) begin
                        state_q    <= S_IDLE;
                        ram_addr_q <= '0;
                    end else begin
                        // ram_addr stays on the bus through the wait.
                        state_q <= S_WAIT;
                        cnt_q   <= CW'(READ_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q          <= S_RESP;
                        ram_addr_q       <= '0;
                        rvalid_q[port_q] <= 1'b1;
                        err_q[port_q]    <= bad_q;
                        if (port_q) begin
                            rdata1_q <= bad_q ? 32'h0 : ram_rdata;
                        end else begin
                            rdata0_q <= bad_q ? 32'h0 : ram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int unsigned WORDS = 64;
    localparam int unsigned LAT   = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic        busy;

    data_mem_arbiter #(
        .RAM_BASE (BASE),
        .RAM_WORDS(WORDS),
        .READ_LAT (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_gnt   (m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata (m0_rdata),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_gnt   (m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata (m1_rdata),
        .m1_err   (m1_err),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    logic [31:0] mem [WORDS];
    initial for (int i = 0; i < int'(WORDS); i++) mem[i] = 32'h0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          gnt_cyc;
    } exp_t;
    exp_t sbq[$];

    // Response monitor: pops the scoreboard on every read response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("exclusive_pulses",
                  32'({m0_gnt & m1_gnt, m0_rvalid & m1_rvalid, m0_err & m1_err}), 32'h0);
            if (m0_rvalid || m1_rvalid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", 32'(m1_rvalid) + 32'h100, 32'h0);
                end else begin
                    e = sbq.pop_front();
                    check("rvalid_port", 32'(m1_rvalid), 32'(e.port));
                    check("rdata", e.port ? m1_rdata : m0_rdata, e.rdata);
                    check("rsp_err", 32'(e.port ? m1_err : m0_err), 32'(e.err));
                    check("rsp_latency", 32'(cyc - e.gnt_cyc), 32'(LAT + 1));
                end
            end
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_idx;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt[14];

    task automatic drive_req(input bit port, input bit req, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (sbq.size() == 0) break;
        end
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        sbq.delete();
    endtask

    task automatic do_access(input vec_t v);
        bit got = 1'b0;
        @(negedge clk);
        drive_req(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (v.port ? m1_gnt : m0_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("gnt_seen", 32'(got), 32'h1);
        if (got) begin
            check("gnt_other_low", 32'(v.port ? m0_gnt : m1_gnt), 32'h0);
            check("busy_at_gnt", 32'(busy), 32'h1);
            check("ram_we", 32'(ram_we), 32'(v.we & ~v.exp_err));
            check("gnt_err", 32'(v.port ? m1_err : m0_err), 32'(v.we & v.exp_err));
            if (!v.exp_err) check("ram_addr", 32'(ram_addr), v.exp_idx);
            if (v.we && !v.exp_err) check("ram_wdata", ram_wdata, v.wdata);
            if (!v.we) sbq.push_back('{v.port, v.exp_rdata, v.exp_err, cyc});
        end
        drive_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid,
                                   m0_err, m1_err, ram_we, busy}), 32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'h0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit winner;
        bit got;
        int a_cyc;

        //           port we  addr          wdata         err idx    rdata
        vt[0]  = '{1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'd2,  32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'd2,  32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 1'b1, 32'h1001_00FC, 32'h1234_5678, 1'b0, 32'd63, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 32'h1001_00FC, 32'h0,         1'b0, 32'd63, 32'h1234_5678};
        vt[4]  = '{1'b1, 1'b1, 32'h1001_0000, 32'hA5A5_0001, 1'b0, 32'd0,  32'h0};
        vt[5]  = '{1'b0, 1'b1, 32'h1001_0100, 32'hCAFE_0000, 1'b1, 32'd0,  32'h0};
        vt[6]  = '{1'b0, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'd0,  32'hA5A5_0001};
        vt[7]  = '{1'b0, 1'b0, 32'h1001_0002, 32'h0,         1'b1, 32'd0,  32'h0};
        vt[8]  = '{1'b1, 1'b1, 32'h1000_FFFC, 32'h5555_5555, 1'b1, 32'd0,  32'h0};
        vt[9]  = '{1'b1, 1'b0, 32'h1001_00FC, 32'h0,         1'b0, 32'd63, 32'h1234_5678};
        vt[10] = '{1'b1, 1'b0, 32'h1001_0100, 32'h0,         1'b1, 32'd0,  32'h0};
        vt[11] = '{1'b0, 1'b1, 32'h1001_0009, 32'h1111_1111, 1'b1, 32'd0,  32'h0};
        vt[12] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'd2,  32'hDEAD_BEEF};
        vt[13] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'd0,  32'h0};

        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        foreach (vt[i]) do_access(vt[i]);

        // Simultaneous requests from a fresh reset alternate 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            drive_req(1'b0, 1'b1, 1'b1, BASE + 32'h10, 32'(r));
            drive_req(1'b1, 1'b1, 1'b1, BASE + 32'h20, 32'(r + 100));
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (m0_gnt || m1_gnt) begin
                    got = 1'b1;
                    break;
                end
            end
            winner = m1_gnt;
            check("rr_gnt_seen", 32'(got), 32'h1);
            check("rr_winner", 32'(winner), 32'(r % 2));
            drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // A request raised while a read is in flight waits for IDLE.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("busy_read_gnt_seen", 32'(got), 32'h1);
        a_cyc = cyc;
        sbq.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0, cyc});
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b1, 1'b1, 32'h1001_0030, 32'h0BAD_F00D);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("held_req_gnt_seen", 32'(got), 32'h1);
        check("held_req_gnt_delay", 32'(cyc - a_cyc), 32'(LAT + 3));
        check("held_req_ram_addr", 32'(ram_addr), 32'd12);
        drive_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        drain();

        // Reset asserted during WAIT discards the read.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 32'h1001_0030, 32'h0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m0_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_read_gnt_seen", 32'(got), 32'h1);
        drive_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("in_wait_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_quiet",
                  32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy}), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
